// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   - load_state_e : loader FSM state encoding
//   - MAGIC_DEFAULT: header tag expected in bits [31:16] of the header word
//   - header field positions and small helpers to split a header word
package uart_imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } load_state_e;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hA5A5;

  localparam int unsigned HDR_MAGIC_MSB = 31;
  localparam int unsigned HDR_MAGIC_LSB = 16;
  localparam int unsigned HDR_COUNT_MSB = 15;
  localparam int unsigned HDR_COUNT_LSB = 0;

  function automatic logic [15:0] header_magic(input logic [31:0] word);
    return word[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  endfunction

  function automatic logic [15:0] header_count(input logic [31:0] word);
    return word[HDR_COUNT_MSB:HDR_COUNT_LSB];
  endfunction

endpackage

// File: rtl/uart_imem_loader_watchdog.sv
// Inter-word watchdog for the loader.
// Counts cycles while enabled and not cleared; flags expiry once the count
// reaches TIMEOUT_CYCLES-1 in a cycle where clear is low.
// Ports:
//   clk_100MHz - system clock
//   rst        - synchronous, active-high reset
//   clear      - restart the count from zero (a word arrived, or not loading)
//   enable     - count only while high
//   expired    - one-cycle pulse when the limit is reached without a clear
module loader_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  assign hit = (cnt_q == LIMIT);

  // Expiry is combinational so the FSM can leave LOAD on the very edge that
  // would otherwise have advanced the count past the limit. A simultaneous
  // clear (an arriving word) suppresses it.
  assign expired = enable & ~clear & hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    cnt_d = cnt_q;
    if (!enable || clear || hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// UART instruction-memory loader.
// Watches assembled 32-bit words from the UART receive path. A header word
// (MAGIC in [31:16], count N in [15:0]) starts a load of N payload words into
// instruction memory at consecutive word addresses from 0. The CPU is held in
// reset until the final word has been written. Bad counts and inter-word
// silence longer than TIMEOUT_CYCLES are reported as errors.
// Ports:
//   clk_100MHz   - system clock
//   rst          - synchronous, active-high reset
//   word_in      - assembled word from the receive buffer
//   word_valid   - word-ready flag; only its rising edges are acted on
//   imem_we      - instruction memory write strobe, one cycle per word
//   imem_addr    - word address of the write
//   imem_wdata   - write data
//   cpu_rst      - CPU reset, high until a load has completed
//   load_done    - load completed
//   load_err     - load aborted (count too large or timeout)
//   words_loaded - payload words written in the current/last load
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] MAGIC          = MAGIC_DEFAULT
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned      PTR_W    = ADDR_W + 1;
  localparam logic [31:0]      CAPACITY = 32'(1) << ADDR_W;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  load_state_e       state_q, state_d;
  logic              valid_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  remaining_q, remaining_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic        rise;
  logic        hdr_ok;
  logic [15:0] hdr_count;
  logic        hdr_too_big;
  logic        restart;
  logic        in_load;
  logic        wd_clear;
  logic        wd_expired;

  // A level already high when reset releases must not count as a new word,
  // which is why valid_q resets to 1.
  assign rise        = word_valid & ~valid_q;
  assign hdr_ok      = (header_magic(word_in) == MAGIC);
  assign hdr_count   = header_count(word_in);
  assign hdr_too_big = ({16'd0, hdr_count} > CAPACITY);
  assign in_load     = (state_q == LOAD);
  // Any valid header outside LOAD restarts the loader, even from DONE/ERROR.
  assign restart     = rise & hdr_ok & ~in_load;
  assign wd_clear    = rise | ~in_load;

  loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_100MHz(clk_100MHz),
    .rst       (rst),
    .clear     (wd_clear),
    .enable    (in_load),
    .expired   (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    remaining_d  = remaining_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (in_load) begin
      // Inside a load every word is payload, even one that looks like a header.
      if (rise) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = wr_ptr_q[ADDR_W-1:0];
        imem_wdata_d = word_in;
        wr_ptr_d     = wr_ptr_q + PTR_ONE;
        remaining_d  = remaining_q - PTR_ONE;
        if (remaining_q == PTR_ONE) begin
          state_d = DONE;
        end
      end else if (wd_expired) begin
        state_d = ERROR;
      end
    end else if (restart) begin
      wr_ptr_d    = '0;
      remaining_d = '0;
      if (hdr_count == 16'd0) begin
        state_d = DONE;
      end else if (hdr_too_big) begin
        state_d = ERROR;
      end else begin
        state_d     = LOAD;
        remaining_d = PTR_W'(hdr_count);
      end
    end

    // Release the CPU only once DONE has been held across an edge, so the
    // release lands one cycle after the final write strobe. A restart
    // re-asserts reset immediately.
    load_done_d = (state_q == DONE) && (state_d == DONE) && !restart;
    cpu_rst_d   = ~load_done_d;
    load_err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b1;
      wr_ptr_q     <= '0;
      remaining_q  <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= word_valid;
      wr_ptr_q     <= wr_ptr_d;
      remaining_q  <= remaining_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  // The write pointer counts payload words written since the last header.
  assign words_loaded = wr_ptr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed scenarios plus a random
// soak, all compared cycle by cycle against a behavioural model of the loader.
module tb_uart_imem_loader;

  localparam int ADDR_W = 8;
  localparam int TMO    = 50;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk_100MHz = 1'b0;
  logic              rst        = 1'b1;
  logic [31:0]       word_in    = '0;
  logic              word_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  uart_imem_loader #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TMO),
    .MAGIC         (16'hA5A5)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst     (cpu_rst),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_cmp = 0;
  int n_bad = 0;
  int we_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOADING, M_FINISHED, M_FAILED} mode_t;
  mode_t       m_mode;
  bit          m_prev;        // last sampled word_valid level
  int          m_left;        // payload words still expected
  int          m_count;       // payload words written this load
  int          m_quiet;       // consecutive cycles without a new word while loading
  int          m_fin_age;     // cycles spent in the finished mode
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_prev    = 1'b1;
    m_left    = 0;
    m_count   = 0;
    m_quiet   = 0;
    m_fin_age = 0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  task automatic model_clock(input bit r, input bit v, input logic [31:0] w);
    bit new_word;
    int n;
    if (r) begin
      model_reset();
      return;
    end
    new_word = v && !m_prev;
    m_prev   = v;
    m_we     = 1'b0;
    if (m_mode == M_LOADING) begin
      if (new_word) begin
        m_we    = 1'b1;
        m_addr  = 32'(m_count % CAP);
        m_data  = w;
        m_count = m_count + 1;
        m_left  = m_left - 1;
        m_quiet = 0;
        if (m_left == 0) begin
          m_mode    = M_FINISHED;
          m_fin_age = 0;
        end
      end else begin
        m_quiet = m_quiet + 1;
        if (m_quiet >= TMO) m_mode = M_FAILED;
      end
    end else if (new_word && w[31:16] == 16'hA5A5) begin
      n       = int'(w[15:0]);
      m_count = 0;
      if (n == 0) begin
        m_mode    = M_FINISHED;
        m_fin_age = 0;
      end else if (n > CAP) begin
        m_mode = M_FAILED;
      end else begin
        m_mode  = M_LOADING;
        m_left  = n;
        m_quiet = 0;
      end
    end else if (m_mode == M_FINISHED) begin
      m_fin_age = m_fin_age + 1;
    end
  endtask

  task automatic compare_outputs();
    bit released;
    released = (m_mode == M_FINISHED) && (m_fin_age >= 1);
    check("imem_we", 32'(imem_we), 32'(m_we));
    if (m_we) begin
      check("imem_addr", 32'(imem_addr), m_addr);
      check("imem_wdata", imem_wdata, m_data);
    end
    check("cpu_rst", 32'(cpu_rst), 32'(!released));
    check("load_done", 32'(load_done), 32'(released));
    check("load_err", 32'(load_err), 32'(m_mode == M_FAILED));
    check("words_loaded", 32'(words_loaded), 32'(m_count));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, sample.
  task automatic step(input bit r, input bit v, input logic [31:0] w);
    rst        = r;
    word_valid = v;
    word_in    = w;
    @(posedge clk_100MHz);
    model_clock(r, v, w);
    #1;
    if (imem_we === 1'b1) we_seen++;
    compare_outputs();
  endtask

  task automatic send_word(input logic [31:0] w, input int hold, input int gap);
    for (int i = 0; i < hold; i++) step(1'b0, 1'b1, w);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, $urandom);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
  endtask

  task automatic do_reset(input bit v, input logic [31:0] w);
    for (int i = 0; i < 2; i++) step(1'b1, v, w);
  endtask

  function automatic logic [31:0] rand_payload();
    logic [31:0] w;
    w = $urandom;
    if (w[31:16] == 16'hA5A5) w[31] = ~w[31];
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish within its time bound");
    $fatal(1, "time bound exceeded");
  end

  initial begin
    int base;
    int n;
    int kind;
    model_reset();
    @(posedge clk_100MHz);
    #1;
    do_reset(1'b0, '0);
    quiet(2);

    // Normal load of three instructions.
    base = we_seen;
    send_word(32'hA5A5_0003, 1, 2);
    send_word(32'h0000_0093, 2, 1);
    send_word(32'h0010_0113, 1, 3);
    send_word(32'h0020_81B3, 1, 3);
    check("normal_writes", 32'(we_seen - base), 3);
    check("normal_words", 32'(words_loaded), 3);
    check("normal_done", 32'(load_done), 1);
    check("normal_cpu_rst", 32'(cpu_rst), 0);

    // Level-held flag: one write per word no matter how long it stays high.
    base = we_seen;
    send_word(32'hA5A5_0002, 20, 1);
    send_word(rand_payload(), 20, 1);
    send_word(rand_payload(), 20, 3);
    check("level_writes", 32'(we_seen - base), 2);

    // Flag already high at reset release is not a new word.
    base = we_seen;
    do_reset(1'b1, 32'hA5A5_0001);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'hA5A5_0001);
    quiet(2);
    check("held_at_release_writes", 32'(we_seen - base), 0);
    check("held_at_release_cpu_rst", 32'(cpu_rst), 1);

    // Bad and boundary headers.
    base = we_seen;
    send_word(32'h1234_0005, 1, 2);
    send_word(rand_payload(), 1, 2);
    check("bad_magic_cpu_rst", 32'(cpu_rst), 1);
    send_word(32'hA5A5_0101, 1, 3);
    check("too_big_err", 32'(load_err), 1);
    send_word(32'hA5A5_0000, 1, 3);
    check("zero_count_done", 32'(load_done), 1);
    check("zero_count_cpu_rst", 32'(cpu_rst), 0);
    check("bad_headers_writes", 32'(we_seen - base), 0);

    // Timeout after 2 of 4 words.
    send_word(32'hA5A5_0004, 1, 2);
    send_word(rand_payload(), 1, 2);
    send_word(rand_payload(), 1, 0);
    quiet(TMO);
    check("timeout_err", 32'(load_err), 1);
    check("timeout_words", 32'(words_loaded), 2);
    check("timeout_cpu_rst", 32'(cpu_rst), 1);

    // A word landing exactly on the expiry cycle is accepted.
    send_word(32'hA5A5_0002, 1, 2);
    send_word(rand_payload(), 1, TMO - 1);
    send_word(rand_payload(), 1, 3);
    check("expiry_word_err", 32'(load_err), 0);
    check("expiry_word_done", 32'(load_done), 1);
    check("expiry_word_count", 32'(words_loaded), 2);

    // Full capacity, then reload.
    send_word(32'hA5A5_0100, 1, 2);
    for (int i = 0; i < CAP; i++)
      send_word(rand_payload(), $urandom_range(1, 2), $urandom_range(1, 3));
    quiet(2);
    check("full_last_addr", 32'(imem_addr), 32'(CAP - 1));
    check("full_words", 32'(words_loaded), 32'(CAP));
    check("full_done", 32'(load_done), 1);
    send_word(32'hA5A5_0001, 1, 0);
    check("reload_cpu_rst", 32'(cpu_rst), 1);
    step(1'b0, 1'b0, '0);
    send_word(rand_payload(), 1, 3);
    check("reload_addr", 32'(imem_addr), 0);
    check("reload_words", 32'(words_loaded), 1);

    // Mid-load reset, then payload-only words.
    send_word(32'hA5A5_0004, 1, 2);
    send_word(rand_payload(), 1, 2);
    send_word(rand_payload(), 1, 2);
    do_reset(1'b0, '0);
    check("midreset_words", 32'(words_loaded), 0);
    check("midreset_cpu_rst", 32'(cpu_rst), 1);
    base = we_seen;
    for (int i = 0; i < 3; i++) send_word(rand_payload(), 1, 2);
    check("midreset_payload_ignored", 32'(we_seen - base), 0);

    // Random soak.
    for (int e = 0; e < 250; e++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 1) begin
        n = ($urandom_range(0, 7) == 0) ? $urandom_range(CAP + 1, 65535) : $urandom_range(0, 6);
        send_word({16'hA5A5, 16'(n)}, $urandom_range(1, 3), $urandom_range(1, 4));
      end else if (kind == 2) begin
        send_word({16'hA5A4, 16'($urandom)}, 1, $urandom_range(1, 4));
      end else if (kind == 3) begin
        quiet($urandom_range(TMO - 5, TMO + 5));
      end else begin
        send_word(rand_payload(), $urandom_range(1, 3), $urandom_range(1, 4));
      end
    end
    quiet(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Downstream consumer of the UART receive path's assembled 32-bit words and their word-ready flag. Parses a header word, then writes the following N words into the RISC-V instruction memory at consecutive word addresses. Holds the CPU in reset during loading and releases it once the load completes. Flags protocol errors: bad count or inter-word timeout.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity 2^ADDR_W words
TIMEOUT_CYCLES, 1000000, max clk_100MHz cycles allowed between consecutive words in LOAD (10 ms)
MAGIC, 16'hA5A5, required value of header word bits [31:16]

Ports:
clk_100MHz  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
word_in  input  32  assembled word from the receive word buffer
word_valid  input  1  word-ready flag; level or pulse; only rising edges count
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  write data
cpu_rst  output  1  CPU reset, high while not loaded
load_done  output  1  high in DONE
load_err  output  1  high in ERROR
words_loaded  output  ADDR_W+1  payload words written in current/last load

Behaviour:
- One clock, clk_100MHz. Reset is synchronous and active-high on rst; it dominates every other input.
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_rst=1, load_done=0, load_err=0, words_loaded=0
  - state=IDLE, valid_q=1 (a level already high at reset release is not a new word), watchdog=0
- Edge detect: rise = word_valid & ~valid_q, with valid_q registered every cycle. All actions below happen only on rise.
- States: IDLE, LOAD, DONE, ERROR.
- Header word: word_in[31:16]==MAGIC. Count N=word_in[15:0].
- IDLE:
  - On a rise with a valid header:
    - N==0 -> DONE.
    - N>2^ADDR_W -> ERROR.
    - Otherwise -> LOAD; wr_ptr=0, remaining=N, words_loaded=0.
  - A rise with a non-header word is ignored and the state stays IDLE.
- LOAD, on each rise:
  - Next edge drives imem_we=1, imem_addr=wr_ptr, imem_wdata=word_in.
  - wr_ptr++, words_loaded++, watchdog cleared.
  - Latency: imem_we is high exactly one cycle, the cycle after the rise is sampled.
  - Words in LOAD are payload even if they match MAGIC.
  - When the Nth word is written, the state moves to DONE on the same edge that raises imem_we.
  - cpu_rst=0 and load_done=1 from the following edge onward, so the CPU is never released before the last write.
- Watchdog (LOAD only):
  - Increments every cycle without a rise; cleared on entry to LOAD and on each rise.
  - Reaching TIMEOUT_CYCLES-1 with no rise -> ERROR.
  - A rise in the same cycle as expiry wins: the word is accepted and the watchdog cleared.
- DONE and ERROR:
  - A rise with a valid header restarts exactly as from IDLE: cpu_rst reasserts, load_done/load_err clear, words_loaded resets.
  - Other words are ignored.
- Outputs in ERROR: load_err=1, cpu_rst=1. words_loaded holds the count written before the fault.
- imem_addr: wr_ptr is ADDR_W+1 bits internally; imem_addr is its low ADDR_W bits. N≤2^ADDR_W guarantees the address never wraps within a load.
- Mid-load reset: returns to IDLE with reset values. Partially written memory is not cleared, and cpu_rst stays high.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERROR=2'd3)
  - MAGIC default
  - header field bit positions (magic [31:16], count [15:0])
- One sub-module: loader_watchdog.
  - Parameter TIMEOUT_CYCLES.
  - Inputs: clk_100MHz, rst, clear, enable.
  - Output: expired, a one-cycle pulse.
- Edge detect and FSM stay inline.

Test Plan:
- Use TIMEOUT_CYCLES=50 for the bench.
- Normal load:
  - Stimulus: header 32'hA5A5_0003, then 32'h00000093, 32'h00100113, 32'h002081B3.
  - Required: writes at addresses 0, 1, 2 with exactly that data; one imem_we pulse each; words_loaded=3.
  - Required: cpu_rst falls one cycle after the third imem_we; load_done=1.
- Level-held word_valid:
  - Stimulus: word_valid held high 20 cycles per word.
  - Required: exactly one write per word.
  - Stimulus: word_valid already high at rst release.
  - Required: no action.
- Bad and boundary headers:
  - 32'h1234_0005 in IDLE -> ignored, state stays IDLE.
  - 32'hA5A5_0101 with ADDR_W=8 -> load_err=1, no writes.
  - 32'hA5A5_0000 -> DONE, cpu_rst=0, no writes.
- Timeout:
  - Stimulus: header N=4, 2 words, then silence for 50 cycles.
  - Required: load_err=1, words_loaded=2, cpu_rst=1.
  - Stimulus: a word arriving on the expiry cycle.
  - Required: word accepted, no error.
- Full capacity and reload:
  - Stimulus: N=256 with ADDR_W=8.
  - Required: last write at address 255, DONE.
  - Stimulus: a new header 32'hA5A5_0001.
  - Required: cpu_rst reasserts, then one write at address 0.
- Mid-load reset:
  - Stimulus: rst pulsed after 2 of 4 words.
  - Required: all outputs return to reset values, state IDLE.
  - Stimulus: subsequent payload-only words.
  - Required: ignored.
